l1_distance_accum: RTL
======================

# l1_distance_accum

Sequential, parametrised successor to the combinational 16-bit subtractor in the K-means datapath. It streams DIMS coordinate pairs (point, centroid), one per handshake. For each pair it computes the absolute difference and accumulates the Manhattan (L1) distance. After DIMS elements it presents the total on a valid/ready output port. It sits between the point/centroid fetch logic and the minimum-distance comparator.

## Interface
- WIDTH, 16, coordinate width in bits.
- DIMS, 4, coordinate pairs per distance; legal range ≥1.
- ACC_W, WIDTH+$clog2(DIMS) (for DIMS=1: WIDTH), accumulator and result width; never overflows.

Ports:
- clk  input  1  rising-edge clock; the block's only clock.
- rst_n  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous abort; discards partial sum and any held result.
- in_valid  input  1  in_a/in_b hold a valid pair.
- in_ready  output  1  block accepts a pair this cycle.
- in_a  input  WIDTH  point coordinate.
- in_b  input  WIDTH  centroid coordinate.
- out_valid  output  1  out_dist holds a completed distance.
- out_ready  input  1  downstream consumes the result.
- out_dist  output  ACC_W  L1 distance, sum of |in_a − in_b| over DIMS pairs.
- busy  output  1  at least one pair has been accepted toward the current distance, or a result is held.

## Operation
- States:
  - ACC: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- Accept occurs when in_valid && in_ready.
- Element arithmetic:
  - diff = in_a − in_b, computed at WIDTH+1 bits.
  - abs = diff negative ? −diff : diff, truncated to WIDTH bits unsigned. Max 2^WIDTH−1, so it is exact.
- Accept in ACC:
  - acc ← acc + abs, with abs zero-extended to ACC_W.
  - idx ← idx + 1.
- Accept with idx == DIMS−1:
  - out_dist ← acc + abs.
  - acc ← 0, idx ← 0.
  - Go to HOLD.
- HOLD with out_ready=1: go to ACC on the next edge; out_valid drops that edge.
- HOLD with out_ready=0: out_dist and out_valid hold stable. No new pairs are accepted (in_ready=0).
- clear=1, either state:
  - Next edge: acc=0, idx=0, state=ACC.
  - out_valid=0; any held result is lost.
  - clear has priority over a simultaneous accept or out_ready.
- DIMS=1: every accept goes directly to HOLD.
- Unsigned comparison by default; signed only under the configuration macro.

## Timing
- Reset (rst_n low, asynchronous) sets:
  - state=ACC, acc=0, idx=0, out_dist=0.
  - out_valid=0, in_ready=1, busy=0.
- Reset mid-distance discards partial state immediately.
- Latency: out_valid rises on the edge that accepts the last pair. It is visible the cycle after that pair was presented.
- Throughput: one pair per cycle in ACC, plus a minimum of one HOLD cycle per distance.
  - With out_ready tied high: DIMS+1 cycles per distance.
  - No input bypass while a result is held.
- in_ready and out_valid are driven from registered state only; no combinational path from out_ready.
- out_dist is stable from out_valid rise until the handshake edge.

## Configuration
- SIGNED_EN:
  - Defined: in_a and in_b are two's-complement signed. diff is sign-extended to WIDTH+1 bits before subtraction, and abs uses the sign of that result.
  - Undefined: both operands are unsigned and zero-extended to WIDTH+1 bits.
  - Result width and all timing are identical in both builds.

## Test plan
- Reset: rst_n low mid-accumulation (after 2 of 4 pairs) -> out_valid=0, in_ready=1, busy=0. A following 4-pair run produces only that run's sum.
- Unsigned basic, WIDTH=16, DIMS=4, out_ready=1, pairs (10,3),(3,10),(0,0),(65535,0) -> out_dist=65549, out_valid high one cycle after the 4th accept.
- Backpressure: out_ready=0 for 5 cycles after a result -> out_dist and out_valid stable, in_ready=0, the pending in_valid pair is not consumed. out_ready=1 -> next distance starts cleanly.
- Max magnitude: four pairs (65535,0) -> out_dist=262140 in 18-bit ACC_W, no wrap.
- SIGNED_EN build, pairs (−32768,32767),(−5,5),(7,−7),(−1,−1) -> out_dist=65535+10+14+0=65559.
- clear asserted together with the last accept of a run -> no out_valid; the next 4 pairs (1,0) each give out_dist=4.

Source files
------------

// File: rtl/l1_distance_accum.sv
// Streams DIMS (point, centroid) pairs, accumulates |a - b| into an L1 distance
// and presents it on a valid/ready port. Define SIGNED_EN for two's-complement operands.
`timescale 1ns/1ps
module l1_distance_accum #(
    parameter int WIDTH = 16,
    parameter int DIMS  = 4,
    parameter int ACC_W = WIDTH + $clog2(DIMS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_dist,
    output logic             busy
);
    localparam int IDX_W = (DIMS > 1) ? $clog2(DIMS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIMS - 1);

    typedef enum logic {ACC = 1'b0, HOLD = 1'b1} state_e;

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] dist_q, dist_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH:0]   a_ext, b_ext, diff;
    logic [WIDTH-1:0] abs_val;
    logic [ACC_W-1:0] sum;
    logic             accept, last;

`ifdef SIGNED_EN
    assign a_ext = {in_a[WIDTH-1], in_a};
    assign b_ext = {in_b[WIDTH-1], in_b};
`else
    assign a_ext = {1'b0, in_a};
    assign b_ext = {1'b0, in_b};
`endif

    // |diff| never exceeds 2^WIDTH-1, so truncating the negation is exact
    assign diff    = a_ext - b_ext;
    assign abs_val = diff[WIDTH] ? WIDTH'(-diff) : WIDTH'(diff);
    assign sum     = acc_q + ACC_W'(abs_val);
    assign accept  = in_valid && (state_q == ACC);
    assign last    = (idx_q == IDX_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACC;
            acc_q   <= '0;
            idx_q   <= '0;
            dist_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            dist_q  <= dist_d;
        end
    end

    // clear outranks both a final accept and the output handshake
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ACC;
        end else if (state_q == ACC) begin
            if (accept && last) state_d = HOLD;
        end else if (out_ready) begin
            state_d = ACC;
        end
    end

    always_comb begin
        acc_d  = acc_q;
        idx_d  = idx_q;
        dist_d = dist_q;
        if (clear) begin
            acc_d = '0;
            idx_d = '0;
        end else if (accept) begin
            if (last) begin
                dist_d = sum;
                acc_d  = '0;
                idx_d  = '0;
            end else begin
                acc_d = sum;
                idx_d = idx_q + 1'b1;
            end
        end
    end

    always_comb begin
        in_ready  = (state_q == ACC);
        out_valid = (state_q == HOLD);
        busy      = (state_q == HOLD) || (idx_q != '0);
    end

    assign out_dist = dist_q;

endmodule
